// File: rtl/trap_unit.sv
// trap_unit -- machine-mode trap and CSR unit for the single-cycle RV32I core.
//
// Owns mstatus/mie/mtvec/mepc/mcause/mtval/mip, executes Zicsr instructions,
// and redirects the PC on trap entry (interrupt, illegal, ecall, ebreak) and
// on mret. All outputs are combinational from inputs and state and are
// forced to 0 while step_en is low. Architectural state only updates on a
// retiring cycle. The ext_int synchroniser and pending latch run every cycle.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   step_en         an instruction retires this cycle
//   pc, inst        current instruction address and word
//   ill_inst, ecall, mret   decoder flags (ecall also covers ebreak)
//   rs1_data        register-file rs1 read data (Zicsr source)
//   ext_int         asynchronous level external interrupt
//   trap_redirect   take trap_pc as next PC
//   trap_pc         redirect target
//   kill_wb         suppress register/memory writeback of this instruction
//   csr_rd_we       write csr_rdata to rd
//   csr_rdata       old CSR value
//   int_pending     latched external interrupt pending
module trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        ill_inst,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] rs1_data,
  input  logic        ext_int,
  output logic        trap_redirect,
  output logic [31:0] trap_pc,
  output logic        kill_wb,
  output logic        csr_rd_we,
  output logic [31:0] csr_rdata,
  output logic        int_pending
);

  // Fewer than two flops is not a safe synchroniser; clamp.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  // Interrupt synchroniser and pending latch
  logic [SS-1:0] sync_q;
  logic          sync_prev_q;
  logic          pend_q, pend_d;

  // CSR state (low two bits of mtvec/mepc are hard-wired zero, not stored)
  logic          mie_q, mie_d;     // mstatus.MIE
  logic          mpie_q, mpie_d;   // mstatus.MPIE
  logic          meie_q, meie_d;   // mie.MEIE
  logic [31:2]   mtvec_q, mtvec_d;
  logic [31:2]   mepc_q, mepc_d;
  logic [31:0]   mcause_q, mcause_d;
  logic [31:0]   mtval_q, mtval_d;

  // Instruction fields
  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  assign csr_addr = inst[31:20];
  assign zimm     = inst[19:15];
  assign funct3   = inst[14:12];
  assign rd       = inst[11:7];

  logic is_csr, eff_ill, take_int, trap, do_mret, csr_we;
  logic [31:0] csr_old, csr_src, csr_wdata, cause, tval;

  assign is_csr  = (inst[6:0] == 7'b1110011) && (funct3 != 3'b000) && (funct3 != 3'b100);
  // The decoder flags Zicsr as illegal; this unit executes them instead.
  assign eff_ill = ill_inst && !is_csr;

  assign take_int = pend_q && mie_q && meie_q;
  assign trap     = step_en && (take_int || eff_ill || ecall);
  assign do_mret  = step_en && mret && !trap;
  // Set/clear with a zero source field is a pure read.
  assign csr_we   = step_en && is_csr && !(funct3[1] && (zimm == 5'd0));

  assign csr_src = funct3[2] ? {27'd0, zimm} : rs1_data;

  always_comb begin
    csr_old = 32'd0;
    case (csr_addr)
      A_MSTATUS: csr_old = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MIE:     csr_old = {20'd0, meie_q, 11'd0};
      A_MTVEC:   csr_old = {mtvec_q, 2'b00};
      A_MEPC:    csr_old = {mepc_q, 2'b00};
      A_MCAUSE:  csr_old = mcause_q;
      A_MTVAL:   csr_old = mtval_q;
      A_MIP:     csr_old = {20'd0, pend_q, 11'd0};
      default:   csr_old = 32'd0;
    endcase
  end

  always_comb begin
    csr_wdata = csr_src;
    case (funct3[1:0])
      2'b10:   csr_wdata = csr_old | csr_src;
      2'b11:   csr_wdata = csr_old & ~csr_src;
      default: csr_wdata = csr_src;
    endcase
  end

  // Trap cause in priority order
  always_comb begin
    cause = 32'd3;
    tval  = pc;
    if (take_int) begin
      cause = 32'h8000_000B;
      tval  = 32'd0;
    end else if (eff_ill) begin
      cause = 32'd2;
      tval  = inst;
    end else if (!inst[20]) begin
      cause = 32'd11;
      tval  = 32'd0;
    end
  end

  // Next CSR state; a trapped instruction's CSR write is dropped.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    if (trap) begin
      mepc_d   = pc[31:2];
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = cause;
      mtval_d  = tval;
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
        end
        A_MIE:    meie_d   = csr_wdata[11];
        A_MTVEC:  mtvec_d  = csr_wdata[31:2];
        A_MEPC:   mepc_d   = csr_wdata[31:2];
        A_MCAUSE: mcause_d = csr_wdata;
        A_MTVAL:  mtval_d  = csr_wdata;
        default:  ;
      endcase
    end
  end

  // A new synchronised rising edge wins over the clear from taking the interrupt.
  assign pend_d = (sync_q[SS-1] && !sync_prev_q) || (pend_q && !(step_en && take_int));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      meie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RESET[31:2];
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
    end else begin
      sync_q      <= {sync_q[SS-2:0], ext_int};
      sync_prev_q <= sync_q[SS-1];
      pend_q      <= pend_d;
      // Gated state already holds its value when step_en is low.
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      meie_q      <= meie_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
    end
  end

  assign trap_redirect = trap || do_mret;
  assign trap_pc       = trap    ? {mtvec_q, 2'b00} :
                         do_mret ? {mepc_q, 2'b00}  : 32'd0;
  assign kill_wb       = trap;
  assign csr_rd_we     = step_en && is_csr && (rd != 5'd0) && !trap;
  assign csr_rdata     = (step_en && is_csr) ? csr_old : 32'd0;
  assign int_pending   = step_en && pend_q;

endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: each test builds a table of per-cycle stimulus with the
// expected combinational outputs, pushes the expectation into a scoreboard
// queue as the stimulus is applied and pops/compares it mid-cycle.
module tb_trap_unit;

  logic        clk, rst, step_en, ill_inst, ecall, mret, ext_int;
  logic [31:0] pc, inst, rs1_data;
  logic        trap_redirect, kill_wb, csr_rd_we, int_pending;
  logic [31:0] trap_pc, csr_rdata;

  trap_unit dut (
    .clk(clk), .rst(rst), .step_en(step_en), .pc(pc), .inst(inst),
    .ill_inst(ill_inst), .ecall(ecall), .mret(mret), .rs1_data(rs1_data),
    .ext_int(ext_int), .trap_redirect(trap_redirect), .trap_pc(trap_pc),
    .kill_wb(kill_wb), .csr_rd_we(csr_rd_we), .csr_rdata(csr_rdata),
    .int_pending(int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en, rs, xi;
    logic [31:0] pc, inst;
    logic        ill, ec, mr;
    logic [31:0] rs1;
  } stim_t;

  typedef struct packed {
    logic        redir;
    logic [31:0] tpc;
    logic        kill, we;
    logic [31:0] rdata;
    logic        pend;
  } obs_t;

  obs_t act;
  assign act = {trap_redirect, trap_pc, kill_wb, csr_rd_we, csr_rdata, int_pending};

  obs_t sb[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  function automatic logic [31:0] csr(input logic [11:0] a, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {a, r1, f3, rd, 7'b1110011};
  endfunction

  function automatic stim_t mk(input logic en, input logic [31:0] p, input logic [31:0] i,
                               input logic il, input logic ec, input logic mr,
                               input logic [31:0] r);
    stim_t s;
    s.en = en; s.rs = 1'b0; s.xi = 1'b0; s.pc = p; s.inst = i;
    s.ill = il; s.ec = ec; s.mr = mr; s.rs1 = r;
    return s;
  endfunction

  function automatic stim_t idle(input logic xi, input logic rs);
    stim_t s;
    s = mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    s.xi = xi; s.rs = rs;
    return s;
  endfunction

  // csrrs x1, <addr>, x0 -- the decoder marks every Zicsr as illegal
  function automatic stim_t rdc(input logic [11:0] a);
    return mk(1'b1, 32'h0, csr(a, 5'd0, 3'b010, 5'd1), 1'b1, 1'b0, 1'b0, 32'h0);
  endfunction

  function automatic obs_t ob(input logic rdr, input logic [31:0] t, input logic k,
                              input logic w, input logic [31:0] d, input logic pd);
    obs_t o;
    o.redir = rdr; o.tpc = t; o.kill = k; o.we = w; o.rdata = d; o.pend = pd;
    return o;
  endfunction

  function automatic obs_t ord(input logic [31:0] d, input logic pd);
    return ob(1'b0, 32'h0, 1'b0, 1'b1, d, pd);
  endfunction

  function automatic obs_t zero();
    return ob(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction

  function automatic obs_t trp(input logic pd);
    return ob(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, pd);
  endfunction

  task automatic drv(input stim_t s);
    @(posedge clk);
    #1;
    step_en = s.en; rst = s.rs; ext_int = s.xi; pc = s.pc; inst = s.inst;
    ill_inst = s.ill; ecall = s.ec; mret = s.mr; rs1_data = s.rs1;
  endtask

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(idle(1'b0, 1'b1)); ex.push_back(zero());
    st.push_back(idle(1'b0, 1'b1)); ex.push_back(zero());
    st.push_back(mk(1'b0, 32'h10, ECALL, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF)); ex.push_back(zero());
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1800, 1'b0));
    st.push_back(rdc(12'h305)); ex.push_back(ord(32'h0, 1'b0));
    st.push_back(rdc(12'h344)); ex.push_back(ord(32'h0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL reset[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_csr();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(mk(1, 0, csr(12'h305, 5'd6, 3'b001, 5'd5), 1, 0, 0, 32'h0000_0103)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h305)); ex.push_back(ord(32'h0000_0100, 0));
    st.push_back(mk(1, 0, csr(12'h304, 5'd7, 3'b001, 5'd0), 1, 0, 0, 32'h0000_0FFF)); ex.push_back(ob(0, 0, 0, 0, 32'h0, 0));
    st.push_back(rdc(12'h304)); ex.push_back(ord(32'h0000_0800, 0));
    st.push_back(mk(1, 0, csr(12'h342, 5'd2, 3'b001, 5'd2), 1, 0, 0, 32'hDEAD_BEEF)); ex.push_back(ord(32'h0, 0));
    st.push_back(mk(1, 0, csr(12'h342, 5'd3, 3'b011, 5'd2), 1, 0, 0, 32'h0000_00FF)); ex.push_back(ord(32'hDEAD_BEEF, 0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'hDEAD_BE00, 0));
    st.push_back(mk(1, 0, csr(12'h7C0, 5'd2, 3'b001, 5'd4), 1, 0, 0, 32'h0000_1234)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h7C0)); ex.push_back(ord(32'h0, 0));
    st.push_back(mk(1, 0, csr(12'h341, 5'd31, 3'b101, 5'd4), 1, 0, 0, 32'hFFFF_FFFF)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_001C, 0));
    st.push_back(mk(1, 0, csr(12'h344, 5'd2, 3'b001, 5'd1), 1, 0, 0, 32'hFFFF_FFFF)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h344)); ex.push_back(ord(32'h0, 0));
    st.push_back(mk(1, 0, csr(12'h300, 5'd2, 3'b001, 5'd1), 1, 0, 0, 32'hFFFF_FFFF)); ex.push_back(ord(32'h0000_1800, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1888, 0));
    st.push_back(mk(1, 0, csr(12'h300, 5'd3, 3'b011, 5'd1), 1, 0, 0, 32'h0000_0088)); ex.push_back(ord(32'h0000_1888, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1800, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL csr[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(mk(1, 32'h40, 32'hFFFF_FFFF, 1, 0, 0, 0)); ex.push_back(trp(0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_0040, 0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'h0000_0002, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'hFFFF_FFFF, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1800, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL illegal[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_ecall_mret();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(mk(1, 0, csr(12'h300, 5'd8, 3'b110, 5'd0), 1, 0, 0, 0)); ex.push_back(ob(0, 0, 0, 0, 32'h0000_1800, 0));
    st.push_back(mk(1, 32'h80, ECALL, 0, 1, 0, 0)); ex.push_back(trp(0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'd11, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1880, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'h0, 0));
    st.push_back(mk(1, 32'h84, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h80, 0, 0, 0, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1888, 0));
    st.push_back(mk(1, 32'h90, EBREAK, 0, 1, 0, 0)); ex.push_back(trp(0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'd3, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'h0000_0090, 0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_0090, 0));
    st.push_back(mk(1, 32'h94, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h90, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ecall_mret[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  // MIE=1, MEIE=1: one-cycle ext_int pulse; pending visible only after the third edge.
  task automatic test_interrupt();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h200, NOP, 0, 0, 0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h204, NOP, 0, 0, 0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h208, NOP, 0, 0, 0, 0)); ex.push_back(trp(1));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'h8000_000B, 0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_0208, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h344)); ex.push_back(ord(32'h0, 0));
    st.push_back(mk(1, 32'h20C, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h208, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL interrupt[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_masked();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(mk(1, 0, csr(12'h300, 5'd8, 3'b111, 5'd0), 1, 0, 0, 0)); ex.push_back(ob(0, 0, 0, 0, 32'h0000_1888, 0));
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h300, NOP, 0, 0, 0, 0)); ex.push_back(ob(0, 0, 0, 0, 0, 1));
    st.push_back(mk(1, 32'h304, csr(12'h300, 5'd8, 3'b110, 5'd0), 1, 0, 0, 0)); ex.push_back(ob(0, 0, 0, 0, 32'h0000_1880, 1));
    st.push_back(mk(1, 32'h308, NOP, 0, 0, 0, 0)); ex.push_back(trp(1));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'h8000_000B, 0));
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h320, NOP, 0, 0, 0, 0)); ex.push_back(ob(0, 0, 0, 0, 0, 1));
    st.push_back(mk(1, 32'h324, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h308, 0, 0, 0, 1));
    st.push_back(mk(1, 32'h328, NOP, 0, 0, 0, 0)); ex.push_back(trp(1));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_0328, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL masked[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; obs_t ex[$]; obs_t e;
    st.push_back(mk(1, 32'h400, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h328, 0, 0, 0, 0));
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h404, 32'hFFFF_FFFF, 1, 0, 0, 0)); ex.push_back(trp(1));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'h8000_000B, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0000_0404, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1880, 0));
    st.push_back(mk(1, 32'h408, MRET, 0, 0, 1, 0)); ex.push_back(ob(1, 32'h404, 0, 0, 0, 0));
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(mk(1, 32'h40C, csr(12'h305, 5'd9, 3'b001, 5'd3), 1, 0, 0, 32'h500)); ex.push_back(ob(1, 32'h100, 1, 0, 32'h100, 1));
    st.push_back(rdc(12'h305)); ex.push_back(ord(32'h0000_0100, 0));
    st.push_back(mk(1, 32'h410, ECALL, 1, 1, 0, 0)); ex.push_back(trp(0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'd2, 0));
    st.push_back(rdc(12'h343)); ex.push_back(ord(32'h0000_0073, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL priority[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; obs_t ex[$]; obs_t e; stim_t s;
    st.push_back(idle(1, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    st.push_back(idle(0, 0)); ex.push_back(zero());
    s = mk(1, 32'h500, NOP, 0, 0, 0, 0); s.rs = 1'b1;
    st.push_back(s); ex.push_back(ob(0, 0, 0, 0, 0, 1));
    st.push_back(mk(1, 32'h504, NOP, 0, 0, 0, 0)); ex.push_back(zero());
    st.push_back(rdc(12'h305)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h300)); ex.push_back(ord(32'h0000_1800, 0));
    st.push_back(rdc(12'h341)); ex.push_back(ord(32'h0, 0));
    st.push_back(rdc(12'h342)); ex.push_back(ord(32'h0, 0));
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back(ex[i]); drv(st[i]); @(negedge clk); e = sb.pop_front(); total++;
      if (act !== e) begin
        bad++;
        $display("FAIL reset_mid[%0d] got redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b want redir=%b pc=%h kill=%b we=%b rdata=%h pend=%b",
                 i, act.redir, act.tpc, act.kill, act.we, act.rdata, act.pend, e.redir, e.tpc, e.kill, e.we, e.rdata, e.pend);
      end
    end
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; ext_int = 1'b0; pc = '0; inst = '0;
    ill_inst = 1'b0; ecall = 1'b0; mret = 1'b0; rs1_data = '0;
    test_reset();
    test_csr();
    test_illegal();
    test_ecall_mret();
    test_interrupt();
    test_masked();
    test_priority();
    test_reset_mid();
    drv(idle(1'b0, 1'b0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
